// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: render reads win, game writes queue in a FIFO, clear sweep on request.
// Define BOARD_ARB_BORDER_EN to force BORDER_COLOR on the outer ring of cells.
module board_ram_arbiter #(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [2:0] CLR_COLOR    = 3'b000,
  parameter logic [2:0] BORDER_COLOR = 3'b111
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pixel_xpos,
  input  logic [9:0]  pixel_ypos,
  output logic [2:0]  pixel_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [10:0] wr_addr,
  input  logic [2:0]  wr_data,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [2:0]  ram_wdata,
  input  logic [2:0]  ram_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [10:0] addr;
    logic [2:0]  data;
  } wr_ent_t;

  state_t        state;
  logic [10:0]   sweep;
  wr_ent_t       fifo [FIFO_DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          step;
  logic          rd_active;
  logic [5:0]    col;
  logic [4:0]    row;
  logic          rd_q;
  logic          sel_rd;
  logic          sel_clr;
  logic          sel_drn;

  assign rd_active = (pixel_xpos >= 10'd1) && (pixel_xpos <= 10'd640)
                  && (pixel_ypos >= 10'd1) && (pixel_ypos <= 10'd480);

  // 16x16 pixel cells: drop the low nibble of the zero-based coordinate
  assign col = 6'((pixel_xpos - 10'd1) >> 4);
  assign row = 5'((pixel_ypos - 10'd1) >> 4);

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;

  assign sel_rd  = rd_active;
  assign sel_clr = !rd_active && (state == CLEAR);
  assign sel_drn = !rd_active && (state == IDLE) && !empty;

  always_comb begin
    ram_addr  = {row, col};
    ram_we    = 1'b0;
    ram_wdata = '0;
    pop       = 1'b0;
    step      = 1'b0;
    unique case (1'b1)
      sel_rd: ram_addr = {row, col};
      sel_clr: begin
        ram_we    = 1'b1;
        ram_addr  = sweep;
        ram_wdata = CLR_COLOR;
        step      = 1'b1;
      end
      sel_drn: begin
        ram_we    = 1'b1;
        ram_addr  = fifo[rp].addr;
        ram_wdata = fifo[rp].data;
        pop       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (push) fifo[wp] <= '{addr: wr_addr, data: wr_data};
  end

`ifdef BOARD_ARB_BORDER_EN
  logic border;
  logic brd_q;

  assign border = (col == 6'd0) || (col == 6'd39)
               || (row == 5'd0) || (row == 5'd29);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) brd_q <= 1'b0;
    else            brd_q <= rd_active && border;
  end

  assign pixel_data = !rd_q ? 3'b000 :
                      brd_q ? BORDER_COLOR : ram_rdata;
`else
  assign pixel_data = rd_q ? ram_rdata : 3'b000;
`endif

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      sweep    <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      rd_q     <= 1'b0;
      rp       <= '0;
      wp       <= '0;
      count    <= '0;
    end else begin
      rd_q     <= rd_active;
      clr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            sweep    <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (step) begin
            sweep <= sweep + 11'd1;
            if (sweep == 11'h7ff) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Randomized bench for board_ram_arbiter with a queue-based reference model
// and a behavioural synchronous board RAM.
module tb_board_ram_arbiter;

  localparam int         DEPTH = 8;
  localparam logic [2:0] CLR   = 3'b000;
  localparam logic [2:0] BRD   = 3'b111;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic [2:0]  pixel_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_addr;
  logic [2:0]  wr_data;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;

  logic [2:0] ram [2048];

  int cmp = 0;
  int bad = 0;

  board_ram_arbiter #(
    .FIFO_DEPTH(DEPTH), .CLR_COLOR(CLR), .BORDER_COLOR(BRD)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .pixel_data(pixel_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // reference model state
  typedef struct {
    logic [10:0] a;
    logic [2:0]  d;
  } ent_t;

  ent_t       q[$];
  logic [2:0] shadow [2048];
  bit         m_clear;
  int         m_sweep;
  bit         m_done;
  bit         p_rd;
  logic [2:0] p_val;

  bit          e_rd;
  bit          e_we;
  bit          e_ready;
  logic [10:0] e_addr;
  logic [2:0]  e_data;
  logic [2:0]  e_pix;

  function automatic bit visible(int x, int y);
    return x >= 1 && x <= 640 && y >= 1 && y <= 480;
  endfunction

  function automatic int cell_of(int x, int y);
    return ((y - 1) / 16) * 64 + (x - 1) / 16;
  endfunction

  function automatic bit on_border(int x, int y);
    int c = (x - 1) / 16;
    int r = (y - 1) / 16;
    return c == 0 || c == 39 || r == 0 || r == 29;
  endfunction

  function automatic void compute_exp();
    int x = int'(pixel_xpos);
    int y = int'(pixel_ypos);
    e_rd = visible(x, y);
    e_we = 0;
    e_addr = '0;
    e_data = '0;
    if (e_rd) e_addr = 11'(cell_of(x, y));
    else if (m_clear) begin
      e_we = 1; e_addr = 11'(m_sweep); e_data = CLR;
    end else if (q.size() > 0) begin
      e_we = 1; e_addr = q[0].a; e_data = q[0].d;
    end
    e_ready = q.size() < DEPTH;
    e_pix = p_rd ? p_val : 3'b000;
  endfunction

  function automatic void model_step();
    bit was_clear = m_clear;
    p_rd = e_rd;
    if (e_rd) begin
      p_val = shadow[e_addr];
`ifdef BOARD_ARB_BORDER_EN
      if (on_border(int'(pixel_xpos), int'(pixel_ypos))) p_val = BRD;
`endif
    end
    m_done = 0;
    if (e_we) begin
      shadow[e_addr] = e_data;
      if (was_clear) begin
        if (m_sweep == 2047) begin
          m_clear = 0; m_done = 1; m_sweep = 0;
        end else m_sweep++;
      end else void'(q.pop_front());
    end
    if (clr_req && !was_clear) begin
      m_clear = 1; m_sweep = 0;
    end
    if (wr_valid && e_ready) q.push_back('{a: wr_addr, d: wr_data});
  endfunction

  function automatic void model_reset();
    q.delete();
    m_clear = 0; m_sweep = 0; m_done = 0; p_rd = 0; p_val = '0;
  endfunction

  task automatic cyc(input int x, input int y, input bit wv,
                     input logic [10:0] wa, input logic [2:0] wd,
                     input bit cr);
    pixel_xpos = 10'(x);
    pixel_ypos = 10'(y);
    wr_valid = wv;
    wr_addr = wa;
    wr_data = wd;
    clr_req = cr;
    @(negedge vga_clk);
    compute_exp();
  endtask

  task automatic adv();
    @(posedge vga_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, '0, '0, 0);
    cmp++; if (pixel_data !== 3'b000) begin bad++; $display("FAIL reset_pix: got %0h want 0", pixel_data); end
    cmp++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", clr_busy); end
    cmp++; if (clr_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", clr_done); end
    cmp++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
    adv();
  endtask

  task automatic test_render();
    ram[{5'd2, 6'd3}] = 3'b101;
    shadow[{5'd2, 6'd3}] = 3'b101;
    cyc(49, 33, 0, '0, '0, 0);
    cmp++; if (ram_addr !== 11'h083) begin bad++; $display("FAIL render_addr: got %0h want 083", ram_addr); end
    cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL render_we: got %b want 0", ram_we); end
    adv();
    cyc(641, 100, 0, '0, '0, 0);
    cmp++; if (pixel_data !== 3'b101) begin bad++; $display("FAIL render_pix: got %0h want 5", pixel_data); end
    adv();
    cyc(100, 0, 0, '0, '0, 0);
    cmp++; if (pixel_data !== 3'b000) begin bad++; $display("FAIL render_x641: got %0h want 0", pixel_data); end
    adv();
    cyc(0, 0, 0, '0, '0, 0);
    cmp++; if (pixel_data !== 3'b000) begin bad++; $display("FAIL render_y0: got %0h want 0", pixel_data); end
    adv();
    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 660), $urandom_range(0, 500), 0, '0, '0, 0);
      cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL render_rnd_we: got %b want 0", ram_we); end
      if (e_rd) begin
        cmp++; if (ram_addr !== e_addr) begin bad++; $display("FAIL render_rnd_addr: got %0h want %0h", ram_addr, e_addr); end
      end
      cmp++; if (pixel_data !== e_pix) begin bad++; $display("FAIL render_rnd_pix: got %0h want %0h", pixel_data, e_pix); end
      adv();
    end
  endtask

  task automatic test_drain();
    cyc(0, 0, 1, 11'h010, 3'b011, 0);
    cmp++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL drain_ready: got %b want 1", wr_ready); end
    cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL drain_early: got %b want 0", ram_we); end
    adv();
    cyc(0, 0, 0, '0, '0, 0);
    cmp++; if (ram_we !== 1'b1 || ram_addr !== 11'h010 || ram_wdata !== 3'b011) begin
      bad++; $display("FAIL drain_write: got we=%b a=%0h d=%0h want 1/010/3", ram_we, ram_addr, ram_wdata);
    end
    adv();
    cyc(0, 0, 0, '0, '0, 0);
    cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL drain_after: got %b want 0", ram_we); end
    adv();
  endtask

  task automatic test_priority();
    ent_t ex[3];
    int k = 0;
    for (int i = 0; i < 20; i++) begin
      bit wv = (i == 2 || i == 7 || i == 13);
      logic [10:0] a = 11'($urandom);
      logic [2:0] d = 3'($urandom);
      if (wv) begin ex[k] = '{a: a, d: d}; k++; end
      cyc($urandom_range(1, 640), $urandom_range(1, 480), wv, a, d, 0);
      cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL prio_we: got %b want 0 at %0d", ram_we, i); end
      adv();
    end
    for (int j = 0; j < 3; j++) begin
      cyc(0, 0, 0, '0, '0, 0);
      cmp++; if (ram_we !== 1'b1 || ram_addr !== ex[j].a || ram_wdata !== ex[j].d) begin
        bad++; $display("FAIL prio_order%0d: got we=%b a=%0h d=%0h want 1/%0h/%0h", j, ram_we, ram_addr, ram_wdata, ex[j].a, ex[j].d);
      end
      adv();
    end
    cyc(0, 0, 0, '0, '0, 0);
    cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL prio_end: got %b want 0", ram_we); end
    adv();
  endtask

  task automatic test_full();
    ent_t ex[DEPTH];
    ent_t xt;
    for (int i = 0; i < DEPTH; i++) begin
      ex[i] = '{a: 11'($urandom), d: 3'($urandom)};
      cyc($urandom_range(1, 640), $urandom_range(1, 480), 1, ex[i].a, ex[i].d, 0);
      cmp++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d: got %b want 1", i, wr_ready); end
      adv();
    end
    xt = '{a: 11'($urandom), d: 3'($urandom)};
    cyc(320, 240, 1, xt.a, xt.d, 0);
    cmp++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_block: got %b want 0", wr_ready); end
    adv();
    cyc(0, 0, 1, xt.a, xt.d, 0);
    cmp++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_pop_same: got %b want 0", wr_ready); end
    cmp++; if (ram_we !== 1'b1 || ram_addr !== ex[0].a || ram_wdata !== ex[0].d) begin
      bad++; $display("FAIL full_pop0: got we=%b a=%0h d=%0h want 1/%0h/%0h", ram_we, ram_addr, ram_wdata, ex[0].a, ex[0].d);
    end
    adv();
    cyc(0, 0, 1, xt.a, xt.d, 0);
    cmp++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_free: got %b want 1", wr_ready); end
    cmp++; if (ram_addr !== ex[1].a || ram_wdata !== ex[1].d) begin
      bad++; $display("FAIL full_pop1: got a=%0h d=%0h want %0h/%0h", ram_addr, ram_wdata, ex[1].a, ex[1].d);
    end
    adv();
    for (int i = 2; i <= DEPTH; i++) begin
      ent_t w = (i == DEPTH) ? xt : ex[i];
      cyc(0, 0, 0, '0, '0, 0);
      cmp++; if (ram_we !== 1'b1 || ram_addr !== w.a || ram_wdata !== w.d) begin
        bad++; $display("FAIL full_pop%0d: got we=%b a=%0h d=%0h want 1/%0h/%0h", i, ram_we, ram_addr, ram_wdata, w.a, w.d);
      end
      adv();
    end
    cyc(0, 0, 0, '0, '0, 0);
    cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", ram_we); end
    adv();
  endtask

  task automatic test_clear();
    int nclr = 0;
    int ndone = 0;
    int last_clr = -1;
    int e_cyc = -1;
    ent_t et = '{a: 11'h2a5, d: 3'b110};
    cyc(0, 0, 0, '0, '0, 1);
    cmp++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_early: got %b want 0", clr_busy); end
    adv();
    for (int i = 0; i < 2055; i++) begin
      cyc(0, 0, i == 700, et.a, et.d, i == 500);
      if (i < 2048) begin
        cmp++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy%0d: got %b want 1", i, clr_busy); end
        cmp++; if (ram_we !== 1'b1 || ram_addr !== 11'(i) || ram_wdata !== CLR) begin
          bad++; $display("FAIL clr_write%0d: got we=%b a=%0h d=%0h want 1/%0h/%0h", i, ram_we, ram_addr, ram_wdata, i, CLR);
        end
      end
      cmp++; if (clr_done !== m_done) begin bad++; $display("FAIL clr_done%0d: got %b want %b", i, clr_done, m_done); end
      if (ram_we && clr_busy) begin nclr++; last_clr = i; end
      if (ram_we && !clr_busy && ram_addr === et.a && ram_wdata === et.d) e_cyc = i;
      if (clr_done) ndone++;
      adv();
    end
    cmp++; if (nclr != 2048) begin bad++; $display("FAIL clr_count: got %0d want 2048", nclr); end
    cmp++; if (ndone != 1) begin bad++; $display("FAIL clr_pulses: got %0d want 1", ndone); end
    cmp++; if (!(e_cyc > last_clr)) begin bad++; $display("FAIL clr_fifo_after: got %0d want > %0d", e_cyc, last_clr); end
  endtask

  task automatic test_reset_mid_sweep();
    bit hit = 0;
    cyc(0, 0, 0, '0, '0, 1);
    adv();
    for (int k = 0; k < 200 && !hit; k++) begin
      bit wv = (k >= 10 && k < 10 + DEPTH);
      cyc(0, 0, wv, 11'($urandom), 3'($urandom), 0);
      if (m_sweep == 100) begin
        hit = 1;
        cmp++; if (ram_addr !== 11'd100 || wr_ready !== 1'b0) begin
          bad++; $display("FAIL mid_state: got a=%0h rdy=%b want 64/0", ram_addr, wr_ready);
        end
        sys_rst_n = 1'b0;
        #1;
        cmp++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", clr_busy); end
        cmp++; if (ram_we !== 1'b0) begin bad++; $display("FAIL mid_we: got %b want 0", ram_we); end
        cmp++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", wr_ready); end
        model_reset();
        @(posedge vga_clk);
        #1;
        sys_rst_n = 1'b1;
      end else adv();
    end
    cmp++; if (!hit) begin bad++; $display("FAIL mid_timeout: got no counter 100 want hit"); end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, '0, '0, 0);
      cmp++; if (clr_done !== 1'b0 || ram_we !== 1'b0) begin
        bad++; $display("FAIL mid_after%0d: got done=%b we=%b want 0/0", i, clr_done, ram_we);
      end
      adv();
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      if ($urandom_range(0, 1)) begin
        x = $urandom_range(1, 640); y = $urandom_range(1, 480);
      end else begin
        x = ($urandom_range(0, 3) == 0) ? $urandom_range(641, 1023) : 0;
        y = $urandom_range(0, 520);
      end
      cyc(x, y, $urandom_range(0, 1), 11'($urandom), 3'($urandom),
          i == 1000 || $urandom_range(0, 1499) == 0);
      cmp++; if (ram_we !== e_we) begin bad++; $display("FAIL rnd_we%0d: got %b want %b", i, ram_we, e_we); end
      if (e_we || e_rd) begin
        cmp++; if (ram_addr !== e_addr) begin bad++; $display("FAIL rnd_addr%0d: got %0h want %0h", i, ram_addr, e_addr); end
      end
      if (e_we) begin
        cmp++; if (ram_wdata !== e_data) begin bad++; $display("FAIL rnd_wdata%0d: got %0h want %0h", i, ram_wdata, e_data); end
      end
      cmp++; if (wr_ready !== e_ready) begin bad++; $display("FAIL rnd_ready%0d: got %b want %b", i, wr_ready, e_ready); end
      cmp++; if (pixel_data !== e_pix) begin bad++; $display("FAIL rnd_pix%0d: got %0h want %0h", i, pixel_data, e_pix); end
      cmp++; if (clr_busy !== m_clear || clr_done !== m_done) begin
        bad++; $display("FAIL rnd_clr%0d: got busy=%b done=%b want %b/%b", i, clr_busy, clr_done, m_clear, m_done);
      end
      adv();
    end
    for (int i = 0; i < 2300 && (q.size() > 0 || m_clear); i++) begin
      cyc(0, 0, 0, '0, '0, 0);
      adv();
    end
    cmp++; if (q.size() > 0 || m_clear) begin bad++; $display("FAIL rnd_flush: got pending=%0d want 0", q.size()); end
    for (int a = 0; a < 2048; a++) if (ram[a] !== shadow[a]) errs++;
    cmp++; if (errs != 0) begin bad++; $display("FAIL rnd_ram: got %0d differing cells want 0", errs); end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin
      ram[a] = 3'($urandom);
      shadow[a] = ram[a];
    end
    pixel_xpos = '0;
    pixel_ypos = '0;
    wr_valid = 0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 0;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    test_reset();
    test_render();
    test_drain();
    test_priority();
    test_full();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
